// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
//   Arbitrates the shared LCD2 parallel bus between the CPU bit-bang path and the
//   hardware frame-push engine. The owner changes only while the bus is idle, and a
//   programmable tristate dead-time separates owners. Ties are broken round-robin.
//   A hold limit can ask a long HW push to yield to a waiting CPU.
//
// Parameters
//   DEAD_CYCLES  tristate cycles inserted before every grant (0 = none)
//   HW_MAX_HOLD  HW ownership cycles before hw_yield may rise (0 = no limit)
//   HOLD_W       width of the hold and dead-time counters
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   cpu_req      CPU bus request, level-held
//   hw_req       HW engine bus request, level-held
//   lcd2_cs_cpu  CPU-side chip select, active-low (1 = idle)
//   lcd2_cs_hw   HW-side chip select, active-low (1 = idle)
//   cpu_gnt      CPU owns the bus
//   hw_gnt       HW owns the bus
//   hw_yield     advisory request for HW to finish and drop hw_req
//   enable       owner select to the bus switch: 00 tristate, 01 CPU, 10 HW
//   busy         arbiter not idle
//
// All outputs are registered and are updated in the same block as the state, so each
// output reflects the state being entered on that edge.

module lcd_bus_arbiter #(
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned HW_MAX_HOLD = 0,
    parameter int unsigned HOLD_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       hw_req,
    input  logic       lcd2_cs_cpu,
    input  logic       lcd2_cs_hw,
    output logic       cpu_gnt,
    output logic       hw_gnt,
    output logic       hw_yield,
    output logic [1:0] enable,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StDead,
        StGrantCpu,
        StGrantHw,
        StDrain
    } state_e;

    localparam logic [1:0] EnOff = 2'b00;
    localparam logic [1:0] EnCpu = 2'b01;
    localparam logic [1:0] EnHw  = 2'b10;

    localparam logic [HOLD_W-1:0] DeadInit  = HOLD_W'(DEAD_CYCLES);
    localparam logic [HOLD_W-1:0] HoldLimit = HOLD_W'(HW_MAX_HOLD);
    localparam logic [HOLD_W-1:0] CntOne    = HOLD_W'(1);

    state_e            state;
    logic              target_hw;   // pending or current owner: 1 = HW, 0 = CPU
    logic              last_hw;     // last granted owner: 1 = HW, 0 = CPU
    logic [HOLD_W-1:0] dead_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic              winner_hw;
    logic              owner_req;
    logic              owner_cs;
    logic [HOLD_W-1:0] hold_inc;

    // A lone request wins; on a tie the side that did not own the bus last wins.
    assign winner_hw = hw_req & (~cpu_req | ~last_hw);
    assign owner_req = target_hw ? hw_req : cpu_req;
    assign owner_cs  = target_hw ? lcd2_cs_hw : lcd2_cs_cpu;
    assign hold_inc  = (&hold_cnt) ? hold_cnt : hold_cnt + CntOne;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            target_hw <= 1'b0;
            last_hw   <= 1'b0;
            dead_cnt  <= '0;
            hold_cnt  <= '0;
            enable    <= EnOff;
            cpu_gnt   <= 1'b0;
            hw_gnt    <= 1'b0;
            hw_yield  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cpu_req || hw_req) begin
                        target_hw <= winner_hw;
                        busy      <= 1'b1;
                        if (DEAD_CYCLES == 0) begin
                            state    <= winner_hw ? StGrantHw : StGrantCpu;
                            last_hw  <= winner_hw;
                            hold_cnt <= '0;
                            hw_yield <= 1'b0;
                            enable   <= winner_hw ? EnHw : EnCpu;
                            cpu_gnt  <= ~winner_hw;
                            hw_gnt   <= winner_hw;
                        end else begin
                            state    <= StDead;
                            dead_cnt <= DeadInit;
                        end
                    end
                end

                StDead: begin
                    if (!owner_req) begin
                        // Target gave up during the dead-time: re-arbitrate from idle.
                        state    <= StIdle;
                        dead_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (dead_cnt <= CntOne) begin
                        state    <= target_hw ? StGrantHw : StGrantCpu;
                        dead_cnt <= '0;
                        last_hw  <= target_hw;
                        hold_cnt <= '0;
                        hw_yield <= 1'b0;
                        enable   <= target_hw ? EnHw : EnCpu;
                        cpu_gnt  <= ~target_hw;
                        hw_gnt   <= target_hw;
                    end else begin
                        dead_cnt <= dead_cnt - CntOne;
                    end
                end

                StGrantCpu: begin
                    if (!cpu_req) begin
                        state   <= StDrain;
                        cpu_gnt <= 1'b0;
                    end
                end

                StGrantHw: begin
                    if (!hw_req) begin
                        state    <= StDrain;
                        hw_gnt   <= 1'b0;
                        hw_yield <= 1'b0;
                    end else begin
                        hold_cnt <= hold_inc;
                        // Sticky until GRANT_HW is left; judged on the count being entered.
                        if ((HW_MAX_HOLD != 0) && cpu_req && (hold_inc >= HoldLimit)) begin
                            hw_yield <= 1'b1;
                        end
                    end
                end

                StDrain: begin
                    // enable keeps the owner value until its chip select goes idle.
                    if (owner_cs) begin
                        state  <= StIdle;
                        enable <= EnOff;
                        busy   <= 1'b0;
                    end
                end

                default: begin
                    state   <= StIdle;
                    enable  <= EnOff;
                    cpu_gnt <= 1'b0;
                    hw_gnt  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Testbench for lcd_bus_arbiter: two instances (DEAD_CYCLES=2/HW_MAX_HOLD=16 and
// DEAD_CYCLES=0/HW_MAX_HOLD=0) share stimulus; each is compared every cycle with a
// behavioural model, plus directed latency, ordering and hold-limit checks.

module tb_lcd_bus_arbiter;

    typedef struct {
        int owner;      // 0 none, 1 CPU, 2 HW currently granted
        int drain;      // owner being drained, 0 if none
        int wait_left;  // remaining dead-time cycles, 0 if not waiting
        int target;
        int last;
        int hold;
        bit yield;
    } model_t;

    logic       clk = 1'b0;
    logic       rst_n, cpu_req, hw_req, cs_cpu, cs_hw;
    logic       a_cg, a_hg, a_y, a_b, z_cg, z_hg, z_y, z_b;
    logic [1:0] a_en, z_en;
    logic [1:0] prev_a = 2'b00, prev_z = 2'b00;
    model_t     m_a, m_z;
    int         n_vec = 0;
    int         n_err = 0;
    bit         any_yield_z = 1'b0;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(.DEAD_CYCLES(2), .HW_MAX_HOLD(16), .HOLD_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .hw_req(hw_req),
        .lcd2_cs_cpu(cs_cpu), .lcd2_cs_hw(cs_hw), .cpu_gnt(a_cg), .hw_gnt(a_hg),
        .hw_yield(a_y), .enable(a_en), .busy(a_b)
    );

    lcd_bus_arbiter #(.DEAD_CYCLES(0), .HW_MAX_HOLD(0), .HOLD_W(16)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .hw_req(hw_req),
        .lcd2_cs_cpu(cs_cpu), .lcd2_cs_hw(cs_hw), .cpu_gnt(z_cg), .hw_gnt(z_hg),
        .hw_yield(z_y), .enable(z_en), .busy(z_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic model_t model_grant(model_t m, int who);
        model_t n = m;
        n.owner = who;
        n.last  = who;
        n.hold  = 0;
        n.yield = 1'b0;
        return n;
    endfunction

    // One clock edge of the arbiter's rules, applied to the inputs seen at that edge.
    function automatic model_t model_step(model_t m, int dead, int limit, bit rst,
                                          bit creq, bit hreq, bit ccs, bit hcs);
        model_t n = m;
        if (!rst) begin
            n.owner = 0; n.drain = 0; n.wait_left = 0; n.target = 0;
            n.last = 1; n.hold = 0; n.yield = 1'b0;
        end else if (m.owner != 0) begin
            if (!((m.owner == 1) ? creq : hreq)) begin
                n.drain = m.owner;
                n.owner = 0;
                n.yield = 1'b0;
            end else if (m.owner == 2) begin
                n.hold = m.hold + 1;
                if (limit != 0 && creq && n.hold >= limit) n.yield = 1'b1;
            end
        end else if (m.drain != 0) begin
            if ((m.drain == 1) ? ccs : hcs) n.drain = 0;
        end else if (m.wait_left > 0) begin
            if (!((m.target == 1) ? creq : hreq)) begin
                n.wait_left = 0;
            end else begin
                n.wait_left = m.wait_left - 1;
                if (n.wait_left == 0) n = model_grant(n, m.target);
            end
        end else if (creq || hreq) begin
            int w;
            if (creq && hreq) w = (m.last == 1) ? 2 : 1;
            else w = hreq ? 2 : 1;
            if (dead == 0) begin
                n = model_grant(n, w);
            end else begin
                n.target    = w;
                n.wait_left = dead;
            end
        end
        return n;
    endfunction

    task automatic check_outputs(input string p, input model_t m, input logic [1:0] en,
                                 input logic cg, input logic hg, input logic y,
                                 input logic b, input logic [1:0] prev_en);
        logic [1:0] e_en;
        e_en = (m.owner != 0) ? 2'(m.owner) : 2'(m.drain);
        check({p, ".enable"}, 32'(en), 32'(e_en));
        check({p, ".cpu_gnt"}, 32'(cg), 32'(m.owner == 1));
        check({p, ".hw_gnt"}, 32'(hg), 32'(m.owner == 2));
        check({p, ".hw_yield"}, 32'(y), 32'(m.yield));
        check({p, ".busy"}, 32'(b), 32'(m.owner != 0 || m.drain != 0 || m.wait_left > 0));
        check({p, ".en_is_11"}, 32'(en == 2'b11), 32'd0);
        check({p, ".en_direct_swap"},
              32'((prev_en == 2'b01 && en == 2'b10) || (prev_en == 2'b10 && en == 2'b01)), 32'd0);
        check({p, ".both_gnt"}, 32'(cg & hg), 32'd0);
    endtask

    // Apply the currently driven inputs for one edge, then check both instances.
    task automatic tick();
        @(posedge clk);
        m_a = model_step(m_a, 2, 16, rst_n, cpu_req, hw_req, cs_cpu, cs_hw);
        m_z = model_step(m_z, 0, 0, rst_n, cpu_req, hw_req, cs_cpu, cs_hw);
        #1;
        check_outputs("a", m_a, a_en, a_cg, a_hg, a_y, a_b, prev_a);
        check_outputs("z", m_z, z_en, z_cg, z_hg, z_y, z_b, prev_z);
        prev_a = a_en;
        prev_z = z_en;
        if (z_y !== 1'b0) any_yield_z = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    // Ticks until instance a grants anyone; n = ticks taken, off = ticks with enable 00.
    task automatic wait_gnt(input string tag, output int n, output int off);
        n   = 0;
        off = 0;
        while (!(a_cg || a_hg) && n < 60) begin
            tick();
            n++;
            if (a_en == 2'b00) off++;
        end
        if (!(a_cg || a_hg)) check({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n, off, who;
        rst_n = 1'b0; cpu_req = 1'b1; hw_req = 1'b1; cs_cpu = 1'b1; cs_hw = 1'b1;
        m_a = '{default: 0};
        m_z = '{default: 0};

        // Reset with both requests high, then HW wins the first tie 3 cycles later.
        do_reset(3);
        check("rst.enable", 32'(a_en), 32'd0);
        check("rst.busy", 32'(a_b), 32'd0);
        wait_gnt("rst", n, off);
        check("rst.first_winner_hw", 32'(a_hg), 32'd1);
        check("rst.latency", 32'(n), 32'd3);

        // Round-robin: owner drops for one cycle and re-raises while the other waits.
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_gnt("rr", n, off);
                check("rr.gap_tristate", 32'(off >= 3), 32'd1);
            end
            who = a_hg ? 2 : 1;
            check("rr.order", 32'(who), (k % 2 == 0) ? 32'd2 : 32'd1);
            for (int i = 0; i < 4; i++) tick();
            if (who == 2) hw_req = 1'b0; else cpu_req = 1'b0;
            tick();
            hw_req = 1'b1; cpu_req = 1'b1;
        end

        // Single CPU request: 3-cycle latency, then drain held by chip select.
        hw_req = 1'b0; cpu_req = 1'b0;
        do_reset(1);
        for (int i = 0; i < 3; i++) tick();
        cpu_req = 1'b1;
        wait_gnt("cpu", n, off);
        check("cpu.latency", 32'(n), 32'd3);
        check("cpu.pre_grant_tristate", 32'(off), 32'd2);
        check("cpu.enable", 32'(a_en), 32'd1);
        cpu_req = 1'b0; cs_cpu = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cpu.drain_gnt", 32'(a_cg), 32'd0);
            check("cpu.drain_enable", 32'(a_en), 32'd1);
        end
        cs_cpu = 1'b1;
        tick();
        check("cpu.after_drain_enable", 32'(a_en), 32'd0);
        tick();

        // Hold limit: CPU arrives 5 cycles into the HW grant; yield at hold_cnt = 16.
        hw_req = 1'b1; cs_hw = 1'b0;
        wait_gnt("hold", n, off);
        n = 0;
        for (int i = 0; i < 40 && a_y !== 1'b1; i++) begin
            if (i == 5) cpu_req = 1'b1;
            tick();
            n++;
        end
        check("hold.yield_cycle", 32'(n), 32'd16);
        for (int i = 0; i < 3; i++) tick();
        check("hold.yield_sticky", 32'(a_y), 32'd1);
        check("hold.still_hw", 32'(a_hg), 32'd1);
        hw_req = 1'b0;
        tick();
        check("hold.yield_clear", 32'(a_y), 32'd0);
        cs_hw = 1'b1;
        tick();
        wait_gnt("hold_cpu", n, off);
        check("hold.cpu_after_drain", 32'(a_cg), 32'd1);
        check("hold.cpu_latency", 32'(n), 32'd3);
        cpu_req = 1'b0;
        tick();
        tick();

        // Abort in DEAD: 2-cycle CPU pulse never reaches a grant on instance a.
        do_reset(1);
        tick();
        cpu_req = 1'b1;
        tick();
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort.enable", 32'(a_en), 32'd0);
            check("abort.cpu_gnt", 32'(a_cg), 32'd0);
        end

        // Reset mid-grant tristates the bus on the next edge.
        hw_req = 1'b1; cs_hw = 1'b0;
        wait_gnt("midrst", n, off);
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst.enable", 32'(a_en), 32'd0);
        check("midrst.hw_gnt", 32'(a_hg), 32'd0);
        rst_n = 1'b1; hw_req = 1'b0; cs_hw = 1'b1;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) cpu_req = ~cpu_req;
            if ($urandom_range(0, 9) == 0) hw_req = ~hw_req;
            cs_cpu = ($urandom_range(0, 3) != 0);
            cs_hw  = ($urandom_range(0, 3) != 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;

        check("z.never_yields", 32'(any_yield_z), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Sequences ownership of the shared LCD2 parallel bus between the CPU bit-bang path and the hardware frame-push engine.
- Drives the 2-bit owner select consumed by the LCD bus switch: 00 = tristate, 01 = CPU, 10 = HW.
- Switches owner only while the bus is idle (CS deasserted), with a programmable tristate dead-time between owners.
- Supports round-robin tie-break and HW hold-time limiting, so a long frame push cannot starve CPU register accesses.

Parameters:
- DEAD_CYCLES, default 2: number of cycles with enable = 00 inserted before every grant; 0 skips the dead-time entirely.
- HW_MAX_HOLD, default 0: cycles of HW ownership after which hw_yield is raised if cpu_req is pending; 0 disables the limit.
- HOLD_W, default 16: width of the hold and dead-time counters.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, synchronous, active-low.
- cpu_req, in, 1: CPU requests the bus, level-held until done.
- hw_req, in, 1: HW engine requests the bus, level-held until done.
- lcd2_cs_cpu, in, 1: CPU-side chip select, active-low; 1 = CPU idle on bus.
- lcd2_cs_hw, in, 1: HW-side chip select, active-low; 1 = HW idle on bus.
- cpu_gnt, out, 1: CPU owns the bus.
- hw_gnt, out, 1: HW owns the bus.
- hw_yield, out, 1: HW is asked to finish its current transfer and drop hw_req.
- enable, out, 2: owner select to the LCD bus switch.
- busy, out, 1: state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset: on any rising edge with rst_n = 0, regardless of state, the arbiter enters IDLE with enable = 00, cpu_gnt = 0, hw_gnt = 0, hw_yield = 0, busy = 0, last_owner = CPU, and all counters cleared. Reset asserted mid-grant therefore tristates the bus on the next edge.
- States are IDLE, DEAD, GRANT_CPU, GRANT_HW and DRAIN.
- IDLE (enable = 00):
  - Exactly one request pending: it wins.
  - Both requests pending: the requester that is not last_owner wins. After reset, HW wins the first tie.
  - The winner is latched as target. Go to DEAD with dead_cnt = DEAD_CYCLES, or go directly to the target's grant state if DEAD_CYCLES = 0.
- DEAD (enable = 00, gnts = 0):
  - dead_cnt decrements each cycle; the state is left after exactly DEAD_CYCLES cycles.
  - If the target's request drops during DEAD, return to IDLE (no grant) and re-arbitrate there.
- Grant latency: 1 + DEAD_CYCLES cycles from the first IDLE cycle seeing the request to the first cycle with the grant high. enable and the grant change in the same cycle.
- GRANT_CPU: enable = 01, cpu_gnt = 1, last_owner <= CPU on entry.
- GRANT_HW: enable = 10, hw_gnt = 1, last_owner <= HW on entry. hold_cnt is cleared on entry and then increments, saturating at its maximum value.
- Hold limit:
  - When HW_MAX_HOLD != 0 and cpu_req = 1 and hold_cnt >= HW_MAX_HOLD, hw_yield = 1.
  - hw_yield stays high until the state leaves GRANT_HW.
  - hw_yield is advisory only; the arbiter never revokes a grant.
- Release: when the owner's request is 0 in a grant state, the next cycle is DRAIN. In DRAIN the grant is 0, enable keeps the owner value, and busy = 1.
- DRAIN exit:
  - Go to IDLE on the first cycle in which the owner's lcd2_cs_* = 1. DRAIN lasts at least 1 cycle.
  - IDLE then forces enable = 00, so every owner change passes through at least 1 + DEAD_CYCLES tristate cycles.
  - The non-owner's request is ignored during DRAIN.
  - An owner that re-raises its request during DRAIN still goes through IDLE and DEAD; it wins only if it is alone or holds the round-robin turn.
- Invariants:
  - cpu_gnt and hw_gnt are never both 1.
  - enable = 11 is never driven.
  - enable never goes directly 01 -> 10 or 10 -> 01.

Test Plan:
All scenarios use DEAD_CYCLES = 2 and HW_MAX_HOLD = 16 unless stated otherwise.
- Reset: hold rst_n = 0 for 3 cycles with both requests high -> enable = 00, both gnts = 0, busy = 0. After release, HW wins the tie and hw_gnt rises 3 cycles after the first IDLE cycle.
- Single CPU: cpu_req raised at cycle 10 -> enable = 00 in cycles 11 and 12; enable = 01 and cpu_gnt = 1 in cycle 13. cpu_req dropped with lcd2_cs_cpu = 0 for 4 further cycles -> cpu_gnt = 0 immediately, enable stays 01 until cs = 1, then enable = 00.
- Round-robin: both requests held continuously through two release cycles -> grants alternate HW, CPU, HW; each switch is separated by at least 3 cycles of enable = 00.
- Hold limit: HW granted, cpu_req raised 5 cycles later -> hw_yield rises when hold_cnt reaches 16. When hw_req drops, hw_yield clears on leaving GRANT_HW, and CPU is granted after drain plus 3 cycles. Repeat with HW_MAX_HOLD = 0 -> hw_yield never asserts.
- Abort in DEAD: cpu_req pulses high for 2 cycles only -> no grant; the arbiter returns to IDLE and enable stays 00 throughout.
- Reset mid-grant: rst_n driven low during GRANT_HW -> enable = 00 and hw_gnt = 0 after that edge. Throughout every scenario, assert that enable never equals 11 and never transitions directly 01 -> 10 or 10 -> 01.
